// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a loadable, bounded up/down index sequencer.
// The index wraps within 0..last and reports wraps and out-of-range loads as one-cycle pulses.
module decoder_seq #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     in,
    input  logic             load,
    input  logic             step,
    input  logic             dir,
    input  logic [N-1:0]     last,
    output logic [2**N-1:0]  out,
    output logic [N-1:0]     idx,
    output logic             wrap,
    output logic             err
);

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   idx_reg, idx_next;
    logic           wrap_reg, wrap_next;
    logic           err_reg, err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= OFF;
            idx_reg   <= '0;
            wrap_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            wrap_reg  <= wrap_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = en ? ON : OFF;
        idx_next   = idx_reg;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        if (load) begin
            // An out-of-range load saturates at the bound rather than being rejected.
            if (in > last) begin
                idx_next = last;
                err_next = 1'b1;
            end else begin
                idx_next = in;
            end
        end else if (step && en) begin
            if (!dir) begin
                // >= also catches a bound that was lowered beneath the current index.
                if (idx_reg >= last) begin
                    idx_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    idx_next = idx_reg + N'(1);
                end
            end else begin
                if (idx_reg == '0) begin
                    idx_next  = last;
                    wrap_next = 1'b1;
                end else if (idx_reg > last) begin
                    idx_next = last;
                end else begin
                    idx_next = idx_reg - N'(1);
                end
            end
        end
    end

    // Each bit is decoded purely from flops, so out only changes at clock edges.
    generate
        for (genvar gi = 0; gi < 2**N; gi++) begin : g_out
            assign out[gi] = (state_reg == ON) && (idx_reg == N'(gi));
        end
    endgenerate

    assign idx  = idx_reg;
    assign wrap = wrap_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: directed scenarios plus randomized traffic,
// all compared against an integer-arithmetic reference model.
module tb_decoder_seq;

    localparam int N = 3;
    localparam int M = 2**N;

    logic           clk = 1'b0;
    logic           rst, en, load, step, dir;
    logic [N-1:0]   in, last;
    logic [M-1:0]   out;
    logic [N-1:0]   idx;
    logic           wrap, err;

    int checks = 0;
    int errors = 0;

    int m_idx, m_out, m_wrap, m_err;

    decoder_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .step(step),
        .dir(dir), .last(last), .out(out), .idx(idx), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    // Advances one clock edge and applies the behavioural rules to the model.
    task automatic tick();
        int lim, cur;
        @(posedge clk);
        lim = int'(last);
        cur = m_idx;
        m_wrap = 0;
        m_err  = 0;
        if (rst) begin
            m_idx = 0;
        end else if (load) begin
            if (int'(in) > lim) begin
                m_idx = lim;
                m_err = 1;
            end else begin
                m_idx = int'(in);
            end
        end else if (step && en) begin
            if (!dir) begin
                if (cur >= lim) begin m_idx = 0; m_wrap = 1; end
                else m_idx = cur + 1;
            end else begin
                if (cur == 0) begin m_idx = lim; m_wrap = 1; end
                else if (cur > lim) m_idx = lim;
                else m_idx = cur - 1;
            end
        end
        m_out = (!rst && en) ? (1 << m_idx) : 0;
        #1;
    endtask

    task automatic set_in(input logic r, e, l, s, d, input int v, lst);
        rst = r; en = e; load = l; step = s; dir = d;
        in = N'(v); last = N'(lst);
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 0, 7);
        tick(); tick();
        checks += 4;
        if (out !== 8'h00) begin errors++; $display("FAIL reset out got %h want 00", out); end
        if (idx !== 3'd0) begin errors++; $display("FAIL reset idx got %0d want 0", idx); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset wrap got %b want 0", wrap); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset err got %b want 0", err); end
        set_in(0, 0, 0, 0, 0, 0, 7);
        tick();
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_en_low out got %h want 00", out); end
        en = 1;
        tick();
        checks += 2;
        if (out !== 8'h01) begin errors++; $display("FAIL reset_en_rise out got %h want 01", out); end
        if (idx !== 3'd0) begin errors++; $display("FAIL reset_en_rise idx got %0d want 0", idx); end
        $display("reset: out=%h idx=%0d", out, idx);
    endtask

    task automatic test_walk_up();
        set_in(0, 1, 1, 0, 0, 0, 7);
        tick();
        load = 0; step = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks += 3;
            if (out !== M'(1 << ((k + 1) % 8))) begin errors++; $display("FAIL walk_up[%0d] out got %h want %h", k, out, 1 << ((k + 1) % 8)); end
            if (wrap !== (k == 7)) begin errors++; $display("FAIL walk_up[%0d] wrap got %b want %b", k, wrap, k == 7); end
            if (idx !== N'(m_idx)) begin errors++; $display("FAIL walk_up[%0d] idx got %0d want %0d", k, idx, m_idx); end
            $display("walk_up step %0d: idx=%0d out=%h wrap=%b", k, idx, out, wrap);
        end
    endtask

    task automatic test_walk_down();
        int exp_idx[3]  = '{0, 5, 4};
        int exp_wrap[3] = '{0, 1, 0};
        set_in(0, 1, 1, 0, 1, 1, 5);
        tick();
        checks++;
        if (idx !== 3'd1) begin errors++; $display("FAIL walk_down_load idx got %0d want 1", idx); end
        load = 0; step = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 3;
            if (idx !== N'(exp_idx[k])) begin errors++; $display("FAIL walk_down[%0d] idx got %0d want %0d", k, idx, exp_idx[k]); end
            if (wrap !== 1'(exp_wrap[k])) begin errors++; $display("FAIL walk_down[%0d] wrap got %b want %0d", k, wrap, exp_wrap[k]); end
            if (out !== M'(m_out)) begin errors++; $display("FAIL walk_down[%0d] out got %h want %h", k, out, m_out); end
            if (k == 1) begin
                checks++;
                if (out !== 8'h20) begin errors++; $display("FAIL walk_down_wrap out got %h want 20", out); end
            end
            $display("walk_down step %0d: idx=%0d out=%h wrap=%b", k, idx, out, wrap);
        end
    endtask

    task automatic test_load_err();
        set_in(0, 1, 1, 0, 0, 6, 4);
        tick();
        checks += 3;
        if (idx !== 3'd4) begin errors++; $display("FAIL load_err idx got %0d want 4", idx); end
        if (out !== 8'h10) begin errors++; $display("FAIL load_err out got %h want 10", out); end
        if (err !== 1'b1) begin errors++; $display("FAIL load_err err got %b want 1", err); end
        load = 0;
        tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL load_err_pulse err got %b want 0", err); end
        set_in(0, 1, 1, 1, 0, 2, 4);
        tick();
        checks += 3;
        if (idx !== 3'd2) begin errors++; $display("FAIL load_step idx got %0d want 2", idx); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL load_step wrap got %b want 0", wrap); end
        if (err !== 1'b0) begin errors++; $display("FAIL load_step err got %b want 0", err); end
        $display("load_err: idx=%0d out=%h err=%b wrap=%b", idx, out, err, wrap);
    endtask

    task automatic test_enable();
        set_in(0, 0, 0, 1, 0, 0, 7);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 2;
            if (out !== 8'h00) begin errors++; $display("FAIL enable_off out got %h want 00", out); end
            if (idx !== N'(m_idx)) begin errors++; $display("FAIL enable_off idx got %0d want %0d", idx, m_idx); end
        end
        set_in(0, 0, 1, 0, 0, 3, 7);
        tick();
        checks += 2;
        if (idx !== 3'd3) begin errors++; $display("FAIL enable_load idx got %0d want 3", idx); end
        if (out !== 8'h00) begin errors++; $display("FAIL enable_load out got %h want 00", out); end
        set_in(0, 1, 0, 0, 0, 0, 7);
        tick();
        checks++;
        if (out !== 8'h08) begin errors++; $display("FAIL enable_on out got %h want 08", out); end
        $display("enable: idx=%0d out=%h", idx, out);
    endtask

    task automatic test_reset_mid();
        set_in(0, 1, 1, 0, 0, 6, 7);
        tick();
        set_in(1, 1, 0, 1, 0, 0, 7);
        tick();
        checks += 4;
        if (idx !== 3'd0) begin errors++; $display("FAIL reset_mid idx got %0d want 0", idx); end
        if (out !== 8'h00) begin errors++; $display("FAIL reset_mid out got %h want 00", out); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_mid wrap got %b want 0", wrap); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_mid err got %b want 0", err); end
        $display("reset_mid: idx=%0d out=%h", idx, out);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom_range(0, 39) == 0);
            en   = ($urandom_range(0, 4) != 0);
            load = ($urandom_range(0, 3) == 0);
            step = ($urandom_range(0, 9) < 6);
            dir  = 1'($urandom_range(0, 1));
            in   = N'($urandom_range(0, M - 1));
            last = ($urandom_range(0, 7) == 0) ? N'(0) : N'($urandom_range(0, M - 1));
            tick();
            checks += 4;
            if (idx !== N'(m_idx)) begin errors++; bad++; $display("FAIL random[%0d] idx got %0d want %0d", k, idx, m_idx); end
            if (out !== M'(m_out)) begin errors++; bad++; $display("FAIL random[%0d] out got %h want %h", k, out, m_out); end
            if (wrap !== 1'(m_wrap)) begin errors++; bad++; $display("FAIL random[%0d] wrap got %b want %0d", k, wrap, m_wrap); end
            if (err !== 1'(m_err)) begin errors++; bad++; $display("FAIL random[%0d] err got %b want %0d", k, err, m_err); end
        end
        $display("random: 400 cycles, %0d discrepancies", bad);
    endtask

    initial begin
        m_idx = 0; m_out = 0; m_wrap = 0; m_err = 0;
        set_in(1, 0, 0, 0, 0, 0, 7);
        test_reset();
        test_walk_up();
        test_walk_down();
        test_load_err();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
